// File: rtl/e800_pkg.sv
// Shared constants for the e800 datapath: bus/register geometry and
// the flag-update select encodings used by the register file.
package e800_pkg;

  localparam int C_ARG_WIDTH  = 8;
  localparam int C_REG_COUNT  = 4;
  localparam int C_ADDR_WIDTH = 2;

  localparam logic [1:0] FLAG_KEEP  = 2'b00;
  localparam logic [1:0] FLAG_ADD   = 2'b01;
  localparam logic [1:0] FLAG_INC   = 2'b10;
  localparam logic [1:0] FLAG_CLEAR = 2'b11;

endpackage

// File: rtl/bus_reg.sv
// Single bus-loadable register with synchronous active-high clear.
module bus_reg
  import e800_pkg::*;
#(
  parameter int c_arg_width = C_ARG_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load,
  input  logic [c_arg_width-1:0] i_d,
  output logic [c_arg_width-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/bus_reg_file.sv
// Register file hanging off the shared tri-state datapath bus: loads from
// the bus, feeds the ALU operands, drives the bus and keeps carry/zero flags.
module bus_reg_file
  import e800_pkg::*;
#(
  parameter int c_arg_width  = C_ARG_WIDTH,
  parameter int c_reg_count  = C_REG_COUNT,
  parameter int c_addr_width = C_ADDR_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  inout  wire  [c_arg_width-1:0]  io_bus,
  input  logic                    i_load,
  input  logic [c_addr_width-1:0] i_load_addr,
  input  logic                    i_enable_out,
  input  logic [c_addr_width-1:0] i_out_addr,
  input  logic [c_addr_width-1:0] i_sel_a,
  input  logic [c_addr_width-1:0] i_sel_b,
  output logic [c_arg_width-1:0]  o_arg1,
  output logic [c_arg_width-1:0]  o_arg2,
  input  logic                    i_add_carry,
  input  logic                    i_inc_carry,
  input  logic [1:0]              i_flag_src,
  output logic                    o_carry,
  output logic                    o_zero
);

  logic [c_arg_width-1:0] reg_q [c_reg_count];
  logic [c_reg_count-1:0] load_en;
  logic                   bus_is_zero;

  // Write decode: exactly one register sees the load strobe.
  for (genvar g = 0; g < c_reg_count; g++) begin : g_regs
    assign load_en[g] = i_load && (i_load_addr == c_addr_width'(g));

    bus_reg #(
      .c_arg_width(c_arg_width)
    ) u_reg (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_load (load_en[g]),
      .i_d    (io_bus),
      .o_q    (reg_q[g])
    );
  end

  assign o_arg1 = reg_q[i_sel_a];
  assign o_arg2 = reg_q[i_sel_b];

  // Self-move works because the edge samples the value this block is driving.
  assign io_bus = i_enable_out ? reg_q[i_out_addr] : {c_arg_width{1'bz}};

  assign bus_is_zero = (io_bus == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
    end else if (i_load) begin
      case (i_flag_src)
        FLAG_ADD: begin
          o_carry <= i_add_carry;
          o_zero  <= bus_is_zero;
        end
        FLAG_INC: begin
          o_carry <= i_inc_carry;
          o_zero  <= bus_is_zero;
        end
        FLAG_CLEAR: begin
          o_carry <= 1'b0;
          o_zero  <= 1'b0;
        end
        default: begin
          o_carry <= o_carry;
          o_zero  <= o_zero;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_reg_file.sv
// Scoreboard bench for bus_reg_file: a behavioural register/flag model
// predicts state, expected reads are queued and popped against the DUT.
module tb_bus_reg_file;
  import e800_pkg::*;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [1:0] la;
  logic       en;
  logic [1:0] oa;
  logic [1:0] sa;
  logic [1:0] sb;
  logic [1:0] fs;
  logic       add_c;
  logic       inc_c;
  logic       tb_drive;
  logic [7:0] tb_val;
  wire  [7:0] bus;
  logic [7:0] arg1;
  logic [7:0] arg2;
  logic       carry;
  logic       zero;

  logic [7:0] mreg [4];
  logic       mc;
  logic       mz;
  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_fail;

  assign bus = tb_drive ? tb_val : 8'bz;

  bus_reg_file dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .io_bus      (bus),
    .i_load      (ld),
    .i_load_addr (la),
    .i_enable_out(en),
    .i_out_addr  (oa),
    .i_sel_a     (sa),
    .i_sel_b     (sb),
    .o_arg1      (arg1),
    .o_arg2      (arg2),
    .i_add_carry (add_c),
    .i_inc_carry (inc_c),
    .i_flag_src  (fs),
    .o_carry     (carry),
    .o_zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sequencer contract: a load always has exactly one bus driver.
  always @(posedge clk) begin
    assert (!(ld && !en && !tb_drive)) else $error("load with undriven bus");
    assert (!(en && tb_drive)) else $error("bus contention");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; src: 0 none, 1 constant dv, 2 adder(sa,sb), 3 incrementer(sa).
  task automatic step(input logic r, input logic l, input logic [1:0] ladr,
                      input logic [1:0] src, input logic [7:0] dv,
                      input logic e, input logic [1:0] oadr,
                      input logic [1:0] f, input logic [1:0] a, input logic [1:0] b);
    logic [8:0] sum;
    logic [8:0] inc;
    logic [7:0] bv;
    logic       ac;
    logic       ic;
    sum = {1'b0, mreg[a]} + {1'b0, mreg[b]};
    inc = {1'b0, mreg[a]} + 9'd1;
    case (src)
      2'd1:    bv = dv;
      2'd2:    bv = sum[7:0];
      2'd3:    bv = inc[7:0];
      default: bv = mreg[oadr];
    endcase
    if (e) bv = mreg[oadr];
    ac = (src == 2'd2) ? sum[8] : 1'b1;
    ic = (src == 2'd3) ? inc[8] : 1'b1;
    rst = r; ld = l; la = ladr; tb_drive = (src != 2'd0); tb_val = bv;
    en = e; oa = oadr; fs = f; sa = a; sb = b; add_c = ac; inc_c = ic;
    #1;
    if (!r) check("pre_edge_arg1", arg1, mreg[a]);
    if (e) check("bus_drive", bus, mreg[oadr]);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
      mc = 1'b0;
      mz = 1'b0;
    end else if (l) begin
      mreg[ladr] = bv;
      case (f)
        FLAG_ADD:   begin mc = ac;   mz = (bv == 8'h00); end
        FLAG_INC:   begin mc = ic;   mz = (bv == 8'h00); end
        FLAG_CLEAR: begin mc = 1'b0; mz = 1'b0; end
        default:    ;
      endcase
    end
    rst = 1'b0; ld = 1'b0; en = 1'b0; tb_drive = 1'b0; fs = FLAG_KEEP;
  endtask

  task automatic verify_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mreg[i]);
      exp_q.push_back(mreg[3-i]);
    end
    exp_q.push_back({7'b0, mc});
    exp_q.push_back({7'b0, mz});
    for (int i = 0; i < 4; i++) begin
      sa = 2'(i);
      sb = 2'(3 - i);
      #1;
      check($sformatf("%s_arg1_r%0d", tag, i), arg1, exp_q.pop_front());
      check($sformatf("%s_arg2_r%0d", tag, 3 - i), arg2, exp_q.pop_front());
    end
    check({tag, "_carry"}, {7'b0, carry}, exp_q.pop_front());
    check({tag, "_zero"}, {7'b0, zero}, exp_q.pop_front());
  endtask

  task automatic bus_release_check(input string tag, input logic [1:0] oadr);
    en = 1'b0; oa = oadr; tb_drive = 1'b1; tb_val = 8'h00;
    #1;
    check(tag, bus, 8'h00);
    tb_drive = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; ld = 1'b0; la = '0; en = 1'b0; oa = '0; sa = '0; sb = '0;
    fs = FLAG_KEEP; add_c = 1'b0; inc_c = 1'b0; tb_drive = 1'b0; tb_val = '0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mc = 1'b0; mz = 1'b0;

    step(1, 0, 0, 0, 8'h00, 0, 0, FLAG_KEEP, 0, 0);
    verify_state("init");

    // Reset after filling every register.
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 1, 8'hAA, 0, 0, FLAG_ADD, 0, 0);
    verify_state("filled");
    bus_release_check("bus_release_filled", 2'd2);
    step(1, 0, 0, 0, 8'h00, 0, 0, FLAG_KEEP, 0, 0);
    verify_state("reset");

    // Load/read; the pre-edge check sees the old value of reg2.
    step(0, 1, 2, 1, 8'h3C, 0, 0, FLAG_KEEP, 2, 0);
    verify_state("load_read");

    // Adder path 254 + 10.
    step(0, 1, 0, 1, 8'd254, 0, 0, FLAG_KEEP, 0, 0);
    step(0, 1, 1, 1, 8'd10, 0, 0, FLAG_KEEP, 0, 0);
    step(0, 1, 3, 2, 8'h00, 0, 0, FLAG_ADD, 0, 1);
    verify_state("add");
    sa = 2'd3;
    #1;
    check("add_result_r3", arg1, 8'd8);
    check("add_carry_flag", {7'b0, carry}, 8'd1);
    step(0, 1, 2, 1, 8'h00, 0, 0, FLAG_KEEP, 0, 0);
    verify_state("keep");
    step(0, 0, 0, 1, 8'h00, 0, 0, FLAG_CLEAR, 0, 0);
    verify_state("noload_flags");

    // Incrementer wraps 255 to 0.
    step(0, 1, 0, 1, 8'd255, 0, 0, FLAG_KEEP, 0, 0);
    step(0, 1, 0, 3, 8'h00, 0, 0, FLAG_INC, 0, 0);
    verify_state("inc");
    check("inc_zero_flag", {7'b0, zero}, 8'd1);
    step(0, 1, 1, 1, 8'h77, 0, 0, FLAG_CLEAR, 0, 0);
    verify_state("clear");

    // Register move and self-move.
    step(0, 1, 1, 1, 8'h5A, 0, 0, FLAG_KEEP, 0, 0);
    step(0, 1, 3, 0, 8'h00, 1, 1, FLAG_KEEP, 0, 0);
    verify_state("move");
    step(0, 1, 3, 0, 8'h00, 1, 3, FLAG_ADD, 3, 0);
    verify_state("self_move");
    check("self_move_r3", arg1, 8'h5A);
    bus_release_check("bus_release_moved", 2'd1);

    // Flags set nonzero, then reset collides with a load.
    step(0, 1, 2, 1, 8'h00, 0, 0, FLAG_ADD, 0, 0);
    verify_state("pre_reset_flags");
    step(1, 1, 0, 1, 8'hFF, 0, 0, FLAG_ADD, 0, 0);
    verify_state("reset_mid_op");

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
